// File: rtl/bus_mailbox.sv
// CPU mailbox on the shared 8-bit bus: a TX byte FIFO drained by a valid/ready consumer,
// an RX byte FIFO filled by a valid/ready producer, plus STATUS/CTRL registers and irq.
module bus_mailbox #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        rd,
    input  logic        wr,
    input  logic [12:0] addr,
    inout  wire  [7:0]  data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    logic             wr_q, rd_q, en_q;
    logic [1:0]       addr_q;
    logic             ie, tx_ovf;
    logic [7:0]       tx_mem [DEPTH];
    logic [7:0]       rx_mem [DEPTH];
    logic [PTR_W-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [PTR_W:0]   tx_cnt, rx_cnt;
    logic [7:0]       rdata;
    logic [1:0]       sel;
    logic             wr_edge, wr_data, wr_ctrl;
    logic             tx_empty, tx_full, tx_push, tx_pop, ovf_set;
    logic             rx_avail, rx_full, rx_push, rx_pop;
    logic             drive;
    logic             unused_addr;

    assign unused_addr = ^addr[12:2];
    assign sel         = addr[1:0];

    // One action per wr assertion: only the rising edge of wr counts.
    assign wr_edge  = en && wr && !wr_q;
    assign wr_data  = wr_edge && (sel == 2'd0);
    assign wr_ctrl  = wr_edge && (sel == 2'd2);

    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_pop   = tx_valid && tx_ready;
    // A concurrent consumer pop frees a slot, so a push into a full FIFO still lands.
    assign tx_push  = wr_data && (!tx_full || tx_pop);
    assign ovf_set  = wr_data && tx_full && !tx_pop;

    assign rx_avail = (rx_cnt != '0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_push  = rx_valid && rx_ready;
    // Pop on the falling edge of rd so the CPU sees a stable head for the whole strobe.
    assign rx_pop   = rd_q && !rd && en_q && (addr_q == 2'd0) && rx_avail;

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_valid ? tx_mem[tx_rp] : 8'h00;
    assign rx_ready = !rx_full;

    always_comb begin
        rdata = 8'h00;
        case (sel)
            2'd0:    rdata = rx_avail ? rx_mem[rx_rp] : 8'h00;
            2'd1:    rdata = {2'b00, ie, tx_ovf, rx_full, rx_avail, tx_full, tx_empty};
            2'd2:    rdata = {7'b0, ie};
            default: rdata = 8'h00;
        endcase
    end

    assign drive = en && rd && !wr;
    assign data  = drive ? rdata : 8'hzz;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= data;
        if (rx_push) rx_mem[rx_wp] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // wr_q held high so a wr strobe straddling reset release is not a new write.
            wr_q   <= 1'b1;
            rd_q   <= 1'b0;
            en_q   <= 1'b0;
            addr_q <= 2'd0;
            ie     <= 1'b0;
            tx_ovf <= 1'b0;
            irq    <= 1'b0;
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            wr_q <= wr;
            rd_q <= rd;
            if (rd) begin
                en_q   <= en;
                addr_q <= sel;
            end
            if (wr_ctrl) begin
                ie <= data[0];
                if (data[1]) tx_ovf <= 1'b0;
            end
            if (ovf_set) tx_ovf <= 1'b1;
            irq <= ie && rx_avail;

            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
                2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
                default: ;
            endcase

            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
                2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
                default: ;
            endcase
        end
    end
endmodule
